spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
- SPI peripheral model and register sitting directly downstream of the SPI master in the switch/LED top.
- Consumes the master's CS/SCLK/SDO.
- Holds one DATA_W-bit register written by PUT frames and returns its contents on the master's SDI line during GET frames.
- Runs fully in the clk domain by oversampling the SPI pins, so it can be instantiated inside top for simulation and on-board loopback.

Parameters:
- DATA_W, 16, width of the stored register and of the data field of a frame.
- SYNC_STAGES, 2, flip-flop synchronizer depth on cs_n, sclk and mosi (minimum 2).
- RESET_VAL, 16'h0000, value loaded into reg_q on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cs_n  in  1  chip select from master (CS), active low.
- sclk  in  1  serial clock from master (SCLK), idle low.
- mosi  in  1  serial data from master (master SDO).
- miso  out  1  serial data to master (master SDI).
- reg_q  out  DATA_W  current register contents.
- wr_strobe  out  1  one-cycle pulse when a PUT frame commits.
- rd_strobe  out  1  one-cycle pulse when a GET frame completes.
- frame_err  out  1  one-cycle pulse when a frame is aborted early.

Behaviour:
- Reset (synchronous, rst=1 at clk posedge):
  - reg_q=RESET_VAL; miso=0; wr_strobe=rd_strobe=frame_err=0.
  - State IDLE; bit counter=0; synchronizers cleared to cs_n=1, sclk=0, mosi=0.
  - Reset asserted mid-frame abandons the frame with no commit and no frame_err.
- Input path: cs_n, sclk and mosi each pass through SYNC_STAGES flops.
  - Edges are detected against one further delayed copy: sclk_rise, sclk_fall, cs_fall, cs_rise.
  - All decisions use the synchronized signals only.
- Frame format, MSB first: 1 command bit (1=PUT/write, 0=GET/read), then DATA_W data bits.
  - Master changes mosi on SCLK falling edges; the slave samples on sclk_rise.
- States: IDLE, CMD, DATA, WAIT_CS.
  - IDLE: on cs_fall go to CMD, clear bit counter and shift_in.
  - CMD: on sclk_rise latch mode=mosi and go to DATA.
    - If mode=0, load shift_out=reg_q and drive miso=reg_q[DATA_W-1] on the next clk.
  - DATA, PUT: on each sclk_rise, shift_in={shift_in[DATA_W-2:0],mosi}; count++.
  - DATA, GET: on each sclk_fall, shift_out<<=1 and miso=new MSB; count++ on sclk_rise.
  - On the sclk_rise that brings count to DATA_W, go to WAIT_CS.
    - PUT: reg_q <= final shifted value in the same clk, and wr_strobe=1 for exactly one cycle.
    - GET: rd_strobe=1 for one cycle; reg_q unchanged.
  - WAIT_CS: ignore all sclk edges and mosi; miso=0. On cs_rise go to IDLE.
- Abort: cs_rise while in CMD or DATA.
  - frame_err=1 for one cycle; return to IDLE; reg_q unchanged; no wr/rd strobe.
- cs_rise and the final sclk_rise in the same clk: the frame commits (strobe fires) and the block goes to IDLE. No frame_err.
- cs_fall while not IDLE (glitch or missed cs_rise): restart at CMD, no commit. frame_err=1 only if the old state was CMD or DATA.
- miso is 0 whenever state is IDLE, CMD, WAIT_CS, or mode=PUT.
- Latency:
  - reg_q updates SYNC_STAGES+1 clk after the raw SCLK edge that carries the last bit.
  - miso updates SYNC_STAGES+1 clk after the raw SCLK falling edge.
- Timing requirement on the master: SCLK high and low phases each ≥ SYNC_STAGES+2 clk periods. CS low-to-first-SCLK-rise ≥ SYNC_STAGES+1 clk.
- Strobes are never asserted in the same cycle as each other.

Test Plan:
- Reset, then GET frame → miso shifts out 0x0000; rd_strobe pulses once; reg_q=0x0000; frame_err=0.
- PUT 0xA5C3 (SCLK phase 4 clk) → wr_strobe single pulse; reg_q=0xA5C3 exactly 3 clk after the 17th raw SCLK rise. Following GET → master captures 0xA5C3.
- PUT 0x1234, then CS raised after 8 data bits → frame_err one pulse; reg_q stays 0xA5C3; no wr_strobe. Next GET returns 0xA5C3.
- Back-to-back PUT 0xFFFF then PUT 0x0001 with CS high for 3 clk between them → reg_q=0xFFFF then 0x0001; two wr_strobe pulses.
- PUT 0xBEEF followed by 3 extra SCLK pulses before CS rises → reg_q=0xBEEF; extra edges ignored; one wr_strobe.
- rst asserted for 1 clk at data bit 10 of PUT 0x5555 → reg_q=0x0000; no strobes. Next GET returns 0x0000.

Source files
------------

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI peripheral holding one DATA_W-bit register.
// The SPI pins are oversampled in the clk domain. A frame is one command bit
// (1 = PUT/write, 0 = GET/read) followed by DATA_W data bits, MSB first.
module spi_reg_slave #(
    parameter int                DATA_W      = 16,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] reg_q,
    output logic              wr_strobe,
    output logic              rd_strobe,
    output logic              frame_err
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        WAIT_CS
    } state_t;

    // Synchronizer chains plus one delayed copy of each for edge detection
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_dly_q, cs_dly_d;
    logic                   sclk_dly_q, sclk_dly_d;

    logic cs_s, sclk_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    // Frame state. shift_in holds the first DATA_W-1 received bits; the last
    // bit comes straight from mosi on the committing edge. shift_out holds
    // the GET bits still to be sent below the one currently on miso.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mode_q, mode_d;
    logic [DATA_W-2:0] shift_in_q, shift_in_d;
    logic [DATA_W-2:0] shift_out_q, shift_out_d;
    logic [DATA_W-1:0] reg_d;
    logic              miso_q, miso_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic              rd_strobe_q, rd_strobe_d;
    logic              frame_err_q, frame_err_d;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;

    assign miso      = miso_q;
    assign wr_strobe = wr_strobe_q;
    assign rd_strobe = rd_strobe_q;
    assign frame_err = frame_err_q;

    // Shift the raw pins through the synchronizers and keep the delayed copies
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_dly_d    = cs_s;
        sclk_dly_d  = sclk_s;
    end

    // Frame decoder: chip-select restarts/aborts take priority over bit traffic
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mode_d      = mode_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        reg_d       = reg_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        frame_err_d = 1'b0;

        if (cs_fall) begin
            frame_err_d = (state_q == CMD) || (state_q == DATA);
            state_d     = CMD;
            count_d     = '0;
            shift_in_d  = '0;
            miso_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    miso_d = 1'b0;
                end
                CMD: begin
                    miso_d = 1'b0;
                    if (cs_rise) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else if (sclk_rise) begin
                        mode_d  = mosi_s;
                        state_d = DATA;
                        if (!mosi_s) begin
                            shift_out_d = reg_q[DATA_W-2:0];
                            miso_d      = reg_q[DATA_W-1];
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        count_d = count_q + 1'b1;
                        if (mode_q) begin
                            shift_in_d = {shift_in_q[DATA_W-3:0], mosi_s};
                        end
                    end
                    if (!mode_q && sclk_fall) begin
                        shift_out_d = {shift_out_q[DATA_W-3:0], 1'b0};
                        miso_d      = shift_out_q[DATA_W-2];
                    end
                    if (sclk_rise && (count_q == LAST_CNT)) begin
                        if (mode_q) begin
                            reg_d       = {shift_in_q, mosi_s};
                            wr_strobe_d = 1'b1;
                        end else begin
                            rd_strobe_d = 1'b1;
                        end
                        miso_d  = 1'b0;
                        state_d = cs_rise ? IDLE : WAIT_CS;
                    end else if (cs_rise) begin
                        frame_err_d = 1'b1;
                        miso_d      = 1'b0;
                        state_d     = IDLE;
                    end
                end
                WAIT_CS: begin
                    miso_d = 1'b0;
                    if (cs_rise) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Register everything; reset abandons any frame in progress silently
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_dly_q    <= 1'b1;
            sclk_dly_q  <= 1'b0;
            state_q     <= IDLE;
            count_q     <= '0;
            mode_q      <= 1'b0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            reg_q       <= RESET_VAL;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_dly_q    <= cs_dly_d;
            sclk_dly_q  <= sclk_dly_d;
            state_q     <= state_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            reg_q       <= reg_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: drives SPI frames as a master would and checks the slave
// every cycle against a frame-level model. Every raw pin edge made by the
// master shows its effect on the outputs SYNC_STAGES+1 clk later, so the model
// schedules expected output changes at that offset from the edge that caused them.
`timescale 1ns/1ps
module tb_spi_reg_slave;

    localparam int                DATA_W      = 16;
    localparam int                SYNC_STAGES = 2;
    localparam int                LAT         = SYNC_STAGES + 1;
    localparam logic [DATA_W-1:0] RESET_VAL   = 16'h0000;
    localparam int                FULL        = DATA_W + 1;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              cs_n = 1'b1;
    logic              sclk = 1'b0;
    logic              mosi = 1'b0;
    logic              miso;
    logic [DATA_W-1:0] reg_q;
    logic              wr_strobe;
    logic              rd_strobe;
    logic              frame_err;

    spi_reg_slave #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (RESET_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .reg_q    (reg_q),
        .wr_strobe(wr_strobe),
        .rd_strobe(rd_strobe),
        .frame_err(frame_err)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    typedef enum int {EV_RESET, EV_REG, EV_WR, EV_RD, EV_ERR, EV_MISO} ev_kind_t;
    typedef struct {
        int                cyc;
        ev_kind_t          kind;
        logic [DATA_W-1:0] val;
    } ev_t;

    ev_t ev_q[$];
    ev_t keep_q[$];

    int  cycle    = 0;
    int  checks   = 0;
    int  failures = 0;
    bit  checking = 1'b0;

    logic [DATA_W-1:0] exp_reg  = RESET_VAL;
    logic              exp_miso = 1'b0;
    logic              exp_wr, exp_rd, exp_err;

    int wr_seen = 0;
    int rd_seen = 0;
    int err_seen = 0;
    int w0, r0, e0;

    logic [DATA_W-1:0] model_reg = RESET_VAL;
    logic [DATA_W-1:0] last_get  = '0;
    logic [DATA_W-1:0] prev_reg  = '0;
    int                last_rise_cyc   = 0;
    int                reg_change_cyc  = 0;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, expected);
        end
    endtask

    function automatic void schedule(input ev_kind_t kind, input logic [DATA_W-1:0] val);
        ev_t e;
        e.cyc  = cycle + LAT;
        e.kind = kind;
        e.val  = val;
        ev_q.push_back(e);
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        ev_t e;
        rst  = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        ev_q.delete();
        e.cyc  = cycle + 1;
        e.kind = EV_RESET;
        e.val  = '0;
        ev_q.push_back(e);
        model_reg = RESET_VAL;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One master frame. nrises = SCLK rises before CS goes high (FULL = whole
    // frame), extra = surplus pulses after a whole frame, cs_with_last raises
    // CS together with the final rise, rst_at resets just before that rise.
    task automatic applyStimulus(input logic cmd, input logic [DATA_W-1:0] data,
                                 input int nrises, input int extra, input bit cs_with_last,
                                 input int rst_at, input int phase);
        logic [DATA_W-1:0] frame_reg;
        logic [DATA_W-1:0] captured;
        logic              nb;
        int                total;
        bit                cs_done;
        frame_reg = model_reg;
        captured  = '0;
        cs_done   = 1'b0;
        total     = (nrises == FULL) ? nrises + extra : nrises;
        cs_n = 1'b0;
        mosi = cmd;
        for (int i = 0; i < total; i++) begin
            waitCycles(phase);
            if (i == rst_at) begin
                doReset();
                return;
            end
            sclk = 1'b1;
            if (i == 0 && !cmd) schedule(EV_MISO, DATA_W'(frame_reg[DATA_W-1]));
            if (i == DATA_W) begin
                last_rise_cyc = cycle;
                if (cmd) begin
                    model_reg = data;
                    schedule(EV_REG, data);
                    schedule(EV_WR, '0);
                end else begin
                    schedule(EV_RD, '0);
                end
                schedule(EV_MISO, '0);
                if (cs_with_last) begin
                    cs_n    = 1'b1;
                    cs_done = 1'b1;
                end
            end
            waitCycles(phase);
            if (!cmd && i < DATA_W) captured = {captured[DATA_W-2:0], miso};
            sclk = 1'b0;
            if (!cmd && i < DATA_W) begin
                if (i < DATA_W - 1) nb = frame_reg[DATA_W-2-i];
                else                nb = 1'b0;
                schedule(EV_MISO, DATA_W'(nb));
            end
            if (i < DATA_W) mosi = data[DATA_W-1-i];
        end
        if (!cs_done) begin
            waitCycles(phase);
            cs_n = 1'b1;
            if (nrises < FULL) begin
                schedule(EV_ERR, '0);
                schedule(EV_MISO, '0);
            end
        end
        mosi = 1'b0;
        if (!cmd && nrises == FULL) begin
            last_get = captured;
            checkOutput("get_data", captured, frame_reg);
        end
    endtask

    task automatic snapCounts();
        w0 = wr_seen;
        r0 = rd_seen;
        e0 = err_seen;
    endtask

    task automatic checkCounts(input string name, input int wr_exp, input int rd_exp, input int err_exp);
        checkOutput({name, "_wr_count"}, DATA_W'(wr_seen - w0), DATA_W'(wr_exp));
        checkOutput({name, "_rd_count"}, DATA_W'(rd_seen - r0), DATA_W'(rd_exp));
        checkOutput({name, "_err_count"}, DATA_W'(err_seen - e0), DATA_W'(err_exp));
    endtask

    // Compare process: apply events due this cycle, then check every output
    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            exp_wr  = 1'b0;
            exp_rd  = 1'b0;
            exp_err = 1'b0;
            keep_q  = {};
            foreach (ev_q[k]) begin
                if (ev_q[k].cyc == cycle) begin
                    case (ev_q[k].kind)
                        EV_RESET: begin
                            exp_reg  = RESET_VAL;
                            exp_miso = 1'b0;
                            checking = 1'b1;
                        end
                        EV_REG:  exp_reg  = ev_q[k].val;
                        EV_WR:   exp_wr   = 1'b1;
                        EV_RD:   exp_rd   = 1'b1;
                        EV_ERR:  exp_err  = 1'b1;
                        EV_MISO: exp_miso = ev_q[k].val[0];
                        default: ;
                    endcase
                end else if (ev_q[k].cyc > cycle) begin
                    keep_q.push_back(ev_q[k]);
                end
            end
            ev_q = keep_q;
            if (checking) begin
                checkOutput("reg_q", reg_q, exp_reg);
                checkOutput("miso", DATA_W'(miso), DATA_W'(exp_miso));
                checkOutput("wr_strobe", DATA_W'(wr_strobe), DATA_W'(exp_wr));
                checkOutput("rd_strobe", DATA_W'(rd_strobe), DATA_W'(exp_rd));
                checkOutput("frame_err", DATA_W'(frame_err), DATA_W'(exp_err));
                if (wr_strobe === 1'b1) wr_seen++;
                if (rd_strobe === 1'b1) rd_seen++;
                if (frame_err === 1'b1) err_seen++;
                if (reg_q !== prev_reg) reg_change_cyc = cycle;
                prev_reg = reg_q;
            end
        end
    end

    // Directed scenarios followed by randomized frames
    initial begin
        logic            r_cmd;
        logic [DATA_W-1:0] r_data;
        int              r_rises, r_extra, r_rst, r_phase;
        bit              r_cswl;

        @(negedge clk);
        doReset();
        waitCycles(4);

        snapCounts();
        applyStimulus(1'b0, 16'hFFFF, FULL, 0, 1'b0, -1, 4);
        waitCycles(6);
        checkOutput("reset_get_value", last_get, 16'h0000);
        checkOutput("reset_get_reg", reg_q, 16'h0000);
        checkCounts("reset_get", 0, 1, 0);

        snapCounts();
        applyStimulus(1'b1, 16'hA5C3, FULL, 0, 1'b0, -1, 4);
        waitCycles(6);
        checkOutput("put_a5c3_reg", reg_q, 16'hA5C3);
        checkOutput("put_a5c3_latency", DATA_W'(reg_change_cyc - last_rise_cyc), 16'd3);
        checkCounts("put_a5c3", 1, 0, 0);
        applyStimulus(1'b0, 16'h0000, FULL, 0, 1'b0, -1, 5);
        waitCycles(6);
        checkOutput("get_a5c3_value", last_get, 16'hA5C3);

        snapCounts();
        applyStimulus(1'b1, 16'h1234, 9, 0, 1'b0, -1, 4);
        waitCycles(6);
        checkOutput("abort_reg", reg_q, 16'hA5C3);
        checkCounts("abort", 0, 0, 1);
        applyStimulus(1'b0, 16'h0000, FULL, 0, 1'b0, -1, 4);
        waitCycles(6);
        checkOutput("get_after_abort", last_get, 16'hA5C3);

        snapCounts();
        applyStimulus(1'b1, 16'hFFFF, FULL, 0, 1'b0, -1, 4);
        checkOutput("b2b_first_reg", reg_q, 16'hFFFF);
        waitCycles(3);
        applyStimulus(1'b1, 16'h0001, FULL, 0, 1'b0, -1, 4);
        waitCycles(6);
        checkOutput("b2b_second_reg", reg_q, 16'h0001);
        checkCounts("b2b", 2, 0, 0);

        snapCounts();
        applyStimulus(1'b1, 16'hBEEF, FULL, 3, 1'b0, -1, 4);
        waitCycles(6);
        checkOutput("extra_sclk_reg", reg_q, 16'hBEEF);
        checkCounts("extra_sclk", 1, 0, 0);

        snapCounts();
        applyStimulus(1'b1, 16'h3C5A, FULL, 0, 1'b1, -1, 4);
        waitCycles(6);
        checkOutput("cs_with_last_reg", reg_q, 16'h3C5A);
        checkCounts("cs_with_last", 1, 0, 0);

        snapCounts();
        applyStimulus(1'b1, 16'h5555, FULL, 0, 1'b0, 10, 4);
        waitCycles(6);
        checkOutput("mid_reset_reg", reg_q, 16'h0000);
        checkCounts("mid_reset", 0, 0, 0);
        applyStimulus(1'b0, 16'h0000, FULL, 0, 1'b0, -1, 4);
        waitCycles(6);
        checkOutput("get_after_reset", last_get, 16'h0000);

        for (int n = 0; n < 40; n++) begin
            r_cmd   = $urandom_range(0, 1) == 1;
            r_data  = DATA_W'($urandom);
            r_phase = $urandom_range(4, 6);
            r_rises = ($urandom_range(0, 9) < 7) ? FULL : $urandom_range(0, DATA_W);
            r_extra = (r_rises == FULL) ? $urandom_range(0, 2) : 0;
            r_cswl  = (r_rises == FULL && r_extra == 0 && $urandom_range(0, 9) == 0);
            r_rst   = ($urandom_range(0, 14) == 0) ? $urandom_range(0, DATA_W) : -1;
            applyStimulus(r_cmd, r_data, r_rises, r_extra, r_cswl, r_rst, r_phase);
            waitCycles($urandom_range(3, 6));
        end

        waitCycles(10);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends with a summary
    initial begin
        #5_000_000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected completion", cycle);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
